// File: rtl/button_event_decoder_if.sv
// Button bus between the raw push-button pins and the time-set logic.
// The decoder is the slave: it receives the raw active-low buttons and
// returns the debounced level plus one-cycle event pulses per channel.
interface button_event_decoder_if #(
  parameter int NBTN = 2
);
  logic [NBTN-1:0] btn_n;          // raw asynchronous buttons, active-low
  logic [NBTN-1:0] pressed;        // debounced level, 1 = held
  logic [NBTN-1:0] press_pulse;    // one cycle on debounced press
  logic [NBTN-1:0] release_pulse;  // one cycle on debounced release
  logic [NBTN-1:0] short_pulse;    // one cycle on release of a hold that never went long
  logic [NBTN-1:0] long_pulse;     // one cycle when the hold reaches the long threshold
  logic [NBTN-1:0] repeat_pulse;   // periodic while held after long_pulse

  modport master (
    output btn_n,
    input  pressed, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse
  );

  modport slave (
    input  btn_n,
    output pressed, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse
  );
endinterface

// File: rtl/button_event_decoder.sv
// Push-button front end for the clock: per channel, a 2-flop synchroniser,
// a consecutive-sample debouncer and a small FSM that turns the debounced
// level into press / release / short / long / auto-repeat one-cycle events.
// Channels are fully independent and share only clk and rst_n.
module button_event_decoder #(
  parameter int NBTN            = 2,
  parameter int DEBOUNCE_CYCLES = 655,
  parameter int LONG_CYCLES     = 32768,
  parameter int REPEAT_CYCLES   = 8192
) (
  input  logic                  clk,
  input  logic                  rst_n,
  button_event_decoder_if.slave bus
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  logic [NBTN-1:0] pressed_w;
  logic [NBTN-1:0] press_w;
  logic [NBTN-1:0] release_w;
  logic [NBTN-1:0] short_w;
  logic [NBTN-1:0] long_w;
  logic [NBTN-1:0] repeat_w;

  for (genvar ch = 0; ch < NBTN; ch++) begin : g_ch
    logic              sync1_q;
    logic              sync2_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              accept;      // debounced level flips on this edge
    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              pressed_q, pressed_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;

    // Debounce: count consecutive synchronised samples that disagree with the
    // accepted level; the level flips on the edge the run reaches its length.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
      db_cnt_d = '0;
      accept   = 1'b0;
      if (~sync2_q != pressed_q) begin
        if (db_cnt_q == DB_LAST) begin
          accept = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    // Event FSM: a release accepted on the same edge as a long/repeat
    // threshold takes priority, so that edge yields only the release events.
    always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      pressed_d = pressed_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d   = HELD;
            pressed_d = 1'b1;
            press_d   = 1'b1;
            hold_d    = '0;
          end
        end
        HELD: begin
          if (accept) begin
            state_d   = IDLE;
            pressed_d = 1'b0;
            release_d = 1'b1;
            short_d   = 1'b1;
            hold_d    = '0;
          end else if (hold_q == LONG_LAST) begin
            state_d = REPEAT;
            long_d  = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        REPEAT: begin
          if (accept) begin
            state_d   = IDLE;
            pressed_d = 1'b0;
            release_d = 1'b1;
            hold_d    = '0;
          end else if (hold_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
            hold_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          pressed_d = 1'b0;
          hold_d    = '0;
        end
      endcase
    end

    // State, counters and registered outputs; synchronous active-low reset.
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q   <= 1'b1;
        sync2_q   <= 1'b1;
        db_cnt_q  <= '0;
        state_q   <= IDLE;
        hold_q    <= '0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        short_q   <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        sync1_q   <= bus.btn_n[ch];
        sync2_q   <= sync1_q;
        db_cnt_q  <= db_cnt_d;
        state_q   <= state_d;
        hold_q    <= hold_d;
        pressed_q <= pressed_d;
        press_q   <= press_d;
        release_q <= release_d;
        short_q   <= short_d;
        long_q    <= long_d;
        repeat_q  <= repeat_d;
      end
    end

    assign pressed_w[ch] = pressed_q;
    assign press_w[ch]   = press_q;
    assign release_w[ch] = release_q;
    assign short_w[ch]   = short_q;
    assign long_w[ch]    = long_q;
    assign repeat_w[ch]  = repeat_q;
  end

  assign bus.pressed       = pressed_w;
  assign bus.press_pulse   = press_w;
  assign bus.release_pulse = release_w;
  assign bus.short_pulse   = short_w;
  assign bus.long_pulse    = long_w;
  assign bus.repeat_pulse  = repeat_w;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder with small timing parameters.
// An edge-numbered behavioural model predicts every output each cycle;
// event edges recorded by the model are pinned against hand-computed values.
module tb_button_event_decoder;
  localparam int NBTN   = 2;
  localparam int DB     = 4;
  localparam int LONG   = 20;
  localparam int REP    = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  button_event_decoder_if #(.NBTN(NBTN)) bus ();

  button_event_decoder #(
    .NBTN(NBTN), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NBTN-1:0] smp_btn;
  logic            smp_rst;
  bit              m_hist1 [NBTN];   // btn sampled on the previous edge
  bit              m_hist2 [NBTN];   // btn sampled two edges ago
  bit              m_lvl   [NBTN];   // accepted level, 1 = held
  int              m_run   [NBTN];   // length of current disagreeing run
  int              m_p     [NBTN];   // edge number of the accepted press
  int              m_rel;            // edges since reset release (first = 1)
  int              m_press_at   [NBTN];
  int              m_release_at [NBTN];
  int              m_long_at    [NBTN];
  int              m_last_rep   [NBTN];
  int              m_nrep       [NBTN];
  int              m_short_seen [NBTN];
  logic [NBTN-1:0] e_pressed, e_press, e_release, e_short, e_long, e_repeat;

  task automatic model_step();
    e_press   = '0;
    e_release = '0;
    e_short   = '0;
    e_long    = '0;
    e_repeat  = '0;
    if (!smp_rst) begin
      m_rel     = 0;
      e_pressed = '0;
      for (int c = 0; c < NBTN; c++) begin
        m_hist1[c] = 1'b1;
        m_hist2[c] = 1'b1;
        m_lvl[c]   = 1'b0;
        m_run[c]   = 0;
        m_p[c]     = 0;
        m_press_at[c]   = -1;
        m_release_at[c] = -1;
        m_long_at[c]    = -1;
        m_last_rep[c]   = -1;
        m_nrep[c]       = 0;
        m_short_seen[c] = 0;
      end
    end else begin
      m_rel++;
      for (int c = 0; c < NBTN; c++) begin
        bit s;
        bit flip;
        int d;
        s          = m_hist2[c];
        m_hist2[c] = m_hist1[c];
        m_hist1[c] = smp_btn[c];
        flip       = 1'b0;
        if ((!s) != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            flip     = 1'b1;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        d = m_rel - m_p[c];
        if (flip && !m_lvl[c]) begin
          m_lvl[c]        = 1'b1;
          m_p[c]          = m_rel;
          e_press[c]      = 1'b1;
          m_press_at[c]   = m_rel;
          m_long_at[c]    = -1;
          m_last_rep[c]   = -1;
          m_nrep[c]       = 0;
        end else if (flip) begin
          m_lvl[c]        = 1'b0;
          e_release[c]    = 1'b1;
          e_short[c]      = (d <= LONG);
          m_release_at[c] = m_rel;
          m_short_seen[c] = (d <= LONG) ? 1 : 0;
        end else if (m_lvl[c]) begin
          if (d == LONG) begin
            e_long[c]    = 1'b1;
            m_long_at[c] = m_rel;
          end else if (d > LONG && ((d - LONG) % REP) == 0) begin
            e_repeat[c]   = 1'b1;
            m_nrep[c]++;
            m_last_rep[c] = m_rel;
          end
        end
        e_pressed[c] = m_lvl[c];
      end
    end
  endtask

  // Compare process: capture inputs at the active edge, predict and compare
  // on the following falling edge.
  initial begin
    forever begin
      @(posedge clk);
      smp_btn = bus.btn_n;
      smp_rst = rst_n;
      @(negedge clk);
      model_step();
      check("pressed",       {30'b0, bus.pressed},       {30'b0, e_pressed});
      check("press_pulse",   {30'b0, bus.press_pulse},   {30'b0, e_press});
      check("release_pulse", {30'b0, bus.release_pulse}, {30'b0, e_release});
      check("short_pulse",   {30'b0, bus.short_pulse},   {30'b0, e_short});
      check("long_pulse",    {30'b0, bus.long_pulse},    {30'b0, e_long});
      check("repeat_pulse",  {30'b0, bus.repeat_pulse},  {30'b0, e_repeat});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input logic [NBTN-1:0] b, input logic r);
    bus.btn_n = b;
    rst_n     = r;
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [NBTN-1:0] b);
    for (int i = 0; i < n; i++) cycle(b, 1'b1);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cycle(2'b11, 1'b0);
  endtask

  initial begin
    logic [NBTN-1:0] lv;
    int              rem [NBTN];
    int              e_final;

    bus.btn_n = 2'b11;
    rst_n     = 1'b0;

    // Reset, idle, then reset asserted with a button down.
    do_reset();
    run(10, 2'b11);
    cycle(2'b10, 1'b0);
    check("idle_no_press", m_press_at[0], -1);

    // Clean click on ch0: first low sample at edge 10, first high at edge 20.
    do_reset();
    run(9, 2'b11);
    run(10, 2'b10);
    run(10, 2'b11);
    check("click_press_edge",   m_press_at[0],   15);
    check("click_release_edge", m_release_at[0], 25);
    check("click_short",        m_short_seen[0], 1);
    check("click_ch1_quiet",    m_press_at[1],   -1);

    // Bounce: runs of 3 low never reach the debounce length.
    do_reset();
    run(5, 2'b11);
    for (int k = 0; k < 5; k++) begin
      run(3, 2'b10);
      run(1, 2'b11);
      run(3, 2'b10);
      run(1, 2'b11);
    end
    check("bounce_no_press", m_press_at[0], -1);
    e_final = m_rel + 1;
    run(12, 2'b10);
    check("bounce_press_edge", m_press_at[0], e_final + 5);
    run(10, 2'b11);

    // Long hold: low sampled edges 10..46, release accepted at 52.
    do_reset();
    run(9, 2'b11);
    run(37, 2'b10);
    run(15, 2'b11);
    check("long_press_edge",   m_press_at[0],   15);
    check("long_long_edge",    m_long_at[0],    35);
    check("long_repeat_count", m_nrep[0],       3);
    check("long_last_repeat",  m_last_rep[0],   50);
    check("long_release_edge", m_release_at[0], 52);
    check("long_no_short",     m_short_seen[0], 0);

    // Both pressed together, ch1 released early, ch0 goes long.
    do_reset();
    run(9, 2'b11);
    run(10, 2'b00);
    run(21, 2'b10);
    check("both_press0",   m_press_at[0],   15);
    check("both_press1",   m_press_at[1],   15);
    check("both_release1", m_release_at[1], 25);
    check("both_long0",    m_long_at[0],    35);
    check("both_held0",    m_release_at[0], -1);
    run(10, 2'b11);

    // Reset at edge 30 while ch0 held; still held afterwards.
    do_reset();
    run(9, 2'b11);
    run(20, 2'b10);
    cycle(2'b10, 1'b0);
    cycle(2'b10, 1'b0);
    run(30, 2'b10);
    check("rst_repress_edge", m_press_at[0],   6);
    check("rst_relong_edge",  m_long_at[0],    26);
    check("rst_no_release",   m_release_at[0], -1);
    run(10, 2'b11);

    // Randomised activity on both channels with occasional resets.
    do_reset();
    lv = 2'b11;
    for (int c = 0; c < NBTN; c++) rem[c] = int'($urandom_range(30, 1));
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NBTN; c++) begin
        if (rem[c] == 0) begin
          lv[c]  = ~lv[c];
          rem[c] = ($urandom_range(1, 0) == 1) ? int'($urandom_range(5, 1))
                                               : int'($urandom_range(70, 5));
        end
        rem[c]--;
      end
      if ($urandom_range(999, 0) == 0) begin
        cycle(lv, 1'b0);
        cycle(lv, 1'b0);
      end else begin
        cycle(lv, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
